// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer driving the NCO control word.
// Single, sawtooth-repeat and triangle chirps with per-tone dwell.
module nco_sweep_ctrl #(
    parameter int FW = 32,
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [FW-1:0] cfg_f_start,
    input  logic [FW-1:0] cfg_f_stop,
    input  logic [FW-1:0] cfg_f_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [1:0]    cfg_mode,
    output logic [FW-1:0] ctrl,
    output logic          nco_rst,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic [CW-1:0] sweep_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t        state;
    logic [FW-1:0] f_start;
    logic [FW-1:0] f_stop;
    logic [FW-1:0] f_step;
    logic [DW-1:0] dwell;
    logic [1:0]    mode;
    logic [DW-1:0] dwell_cnt;

    logic [FW:0] sum;
    logic [FW:0] diff;
    logic        up_ok;
    logic        dn_ok;

    // Extra MSB catches carry/borrow, which counts as out of range.
    assign sum   = {1'b0, ctrl} + {1'b0, f_step};
    assign diff  = {1'b0, ctrl} - {1'b0, f_step};
    assign up_ok = !sum[FW] && (sum[FW-1:0] <= f_stop);
    assign dn_ok = !diff[FW] && (diff[FW-1:0] >= f_start);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ctrl      <= '0;
            nco_rst   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            sweep_cnt <= '0;
            dwell_cnt <= '0;
            f_start   <= '0;
            f_stop    <= '0;
            f_step    <= '0;
            dwell     <= '0;
            mode      <= '0;
        end else begin
            nco_rst <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        f_start <= cfg_f_start;
                        f_stop  <= cfg_f_stop;
                        f_step  <= cfg_f_step;
                        dwell   <= cfg_dwell;
                        mode    <= cfg_mode;
                        if (cfg_f_start > cfg_f_stop) begin
                            cfg_err <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            state     <= UP;
                            ctrl      <= cfg_f_start;
                            nco_rst   <= 1'b1;
                            busy      <= 1'b1;
                            cfg_err   <= 1'b0;
                            sweep_cnt <= '0;
                            dwell_cnt <= cfg_dwell;
                        end
                    end
                end
                UP, DOWN: begin
                    if (abort) begin
                        state <= IDLE;
                        ctrl  <= '0;
                        busy  <= 1'b0;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else begin
                        dwell_cnt <= dwell;
                        if (state == UP) begin
                            if (up_ok) begin
                                ctrl <= sum[FW-1:0];
                            end else begin
                                case (mode)
                                    2'b01: begin
                                        ctrl      <= f_start;
                                        sweep_cnt <= sweep_cnt + 1'b1;
                                    end
                                    2'b10: begin
                                        state <= DOWN;
                                        if (dn_ok)
                                            ctrl <= diff[FW-1:0];
                                    end
                                    default: begin
                                        state <= IDLE;
                                        ctrl  <= '0;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                    end
                                endcase
                            end
                        end else begin
                            if (dn_ok) begin
                                ctrl <= diff[FW-1:0];
                                if (diff[FW-1:0] == f_start)
                                    sweep_cnt <= sweep_cnt + 1'b1;
                            end else begin
                                state <= UP;
                                if (up_ok)
                                    ctrl <= sum[FW-1:0];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Sequencer that drives the 32-bit frequency control word of the quarter-LUT NCO to produce stepped frequency sweeps (chirps) for the FM/test-tone path.
- Latches a sweep configuration on a start request, then steps the control word from a start frequency toward a stop frequency, holding each tone for a programmable dwell.
- Supports single, repeating-sawtooth and triangle sweeps.
- Issues a one-cycle phase reset to the NCO at sweep start.
- Reports busy/done/error status to the host logic.

Parameters:
FW, 32, frequency control word width (matches NCO ctrl)
DW, 16, dwell counter width
CW, 16, completed-sweep counter width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle sweep request, sampled in IDLE only
abort  input  1  terminates sweep; has priority over start
cfg_f_start  input  FW  first tone control word (unsigned)
cfg_f_stop  input  FW  upper bound control word (unsigned)
cfg_f_step  input  FW  increment per tone (unsigned)
cfg_dwell  input  DW  each tone held cfg_dwell+1 cycles
cfg_mode  input  2  00 single, 01 repeat sawtooth, 10 triangle, 11 reserved (treated as single)
ctrl  output  FW  registered frequency word to NCO ctrl
nco_rst  output  1  registered active-high one-cycle NCO phase reset
busy  output  1  high while sweeping
done  output  1  one-cycle pulse on normal completion of single sweep
cfg_err  output  1  sticky config error, cleared on next accepted start
sweep_cnt  output  CW  completed sweeps since last start; wraps modulo 2^CW

Behaviour:
- Reset (rst low, asynchronous): state IDLE; ctrl=0, nco_rst=0, busy=0, done=0, cfg_err=0, sweep_cnt=0, dwell counter=0, latched config=0.
- States: IDLE, UP, DOWN. All outputs registered.
- Config is latched only when start is accepted. cfg_* changes during a sweep have no effect.
- Accept (IDLE, start=1, abort=0), edge N:
  - Error case: if cfg_f_start > cfg_f_stop, at N+1 set cfg_err=1 and pulse done=1; stay IDLE; ctrl stays 0.
  - Normal case: at N+1 set ctrl=cfg_f_start, nco_rst=1 (exactly one cycle), busy=1, cfg_err=0, sweep_cnt=0, dwell counter=cfg_dwell; state UP.
- Dwell:
  - In UP/DOWN the counter decrements each cycle.
  - When it reads 0, that edge performs a step and reloads the counter to the latched dwell. No idle cycle between tones, so every tone occupies exactly dwell+1 cycles.
- Step arithmetic: use FW+1-bit sums/differences. Carry-out or borrow counts as out of range.
- UP step:
  - If ctrl+step has no carry and is <= f_stop: ctrl <= ctrl+step.
  - Otherwise, by mode:
    - Single: state IDLE, ctrl<=0, busy<=0, done<=1 for one cycle.
    - Repeat: ctrl<=f_start, sweep_cnt++. No nco_rst.
    - Triangle: state DOWN. If ctrl-step has no borrow and is >= f_start, ctrl<=ctrl-step; else ctrl holds.
- DOWN step (triangle only):
  - If ctrl-step has no borrow and is >= f_start: ctrl<=ctrl-step. If the new value equals f_start, sweep_cnt++ on the same edge.
  - Otherwise: state UP and apply the UP increment rule once (ctrl+step if in range, else hold).
  - Endpoints are never repeated.
- Degenerate configs:
  - step=0: ctrl holds f_start indefinitely in every mode; single never completes; leave via abort only.
  - f_start=f_stop: single completes after one dwell; repeat reloads the same value each dwell with sweep_cnt++; triangle holds.
- abort=1 in UP/DOWN: next edge state IDLE, ctrl=0, busy=0, nco_rst=0. done is not pulsed; sweep_cnt and cfg_err hold.
- abort=1 in IDLE: no effect, and start is ignored that cycle.
- start while busy: ignored.
- done and nco_rst are never high in the same cycle as busy rising, except nco_rst, which rises together with busy.
- Reset asserted mid-sweep: immediate return to reset values. No done pulse.

Test Plan:
- Single up: f_start=100, step=50, f_stop=260, dwell=2, mode=00; start at edge N -> nco_rst=1 at N+1 only; ctrl=100 for cycles N+1..N+3, then 150, 200, 250 (3 cycles each); at N+13 ctrl=0, busy=0, done=1 for one cycle; sweep_cnt=0.
- Repeat with overflow: f_start=0, step=0x4000_0000, f_stop=0xFFFF_FFFF, dwell=0, mode=01 -> ctrl sequence 0, 0x4000_0000, 0x8000_0000, 0xC000_0000, 0, ... one per cycle; sweep_cnt increments on each return to 0 (1 after 4 cycles); busy stays 1.
- Triangle: f_start=10, f_stop=30, step=10, dwell=0, mode=10 -> ctrl 10, 20, 30, 20, 10, 20, 30, ...; sweep_cnt=1 on the first return to 10, then 2 on the next; endpoints never repeat.
- Config error: f_start=500, f_stop=400, start -> next cycle cfg_err=1, done=1, busy=0, ctrl=0; a following valid start clears cfg_err.
- Abort and contention: abort mid-dwell at ctrl=150 -> next cycle ctrl=0, busy=0, no done; start and abort together in IDLE -> stays IDLE; start while busy -> sequence unchanged.
- Async reset: drive rst low between clock edges mid-sweep -> ctrl, busy, nco_rst, sweep_cnt read 0 immediately, before the next clock edge; after release, IDLE until start.
